// File: rtl/vga_timing_pkg.sv
// Shared phase encoding and default 640x480@60 timing
// constants for the VGA raster timing core.
package vga_timing_pkg;

  typedef enum logic [1:0] {
    ST_ACTIVE = 2'd0,
    ST_FRONT  = 2'd1,
    ST_SYNC   = 2'd2,
    ST_BACK   = 2'd3
  } phase_t;

  localparam int H_ACTIVE_D = 640;
  localparam int H_FRONT_D  = 16;
  localparam int H_SYNC_D   = 96;
  localparam int H_BACK_D   = 48;

  localparam int V_ACTIVE_D = 480;
  localparam int V_FRONT_D  = 10;
  localparam int V_SYNC_D   = 2;
  localparam int V_BACK_D   = 33;

  localparam bit SYNC_POL_D = 1'b0;

endpackage

// File: rtl/vga_timing_if.sv
// Raster bundle: pixel-advance enable in, sync/position/
// strobe outputs toward the pattern and bitmap stages.
interface vga_timing_if;

  logic       ce;
  logic       hsync;
  logic       vsync;
  logic       display_on;
  logic [9:0] hpos;
  logic [9:0] vpos;
  logic       line_end;
  logic       frame_start;
  logic [7:0] frame_cnt;

  modport master (
    input  ce,
    output hsync, vsync, display_on,
    output hpos, vpos,
    output line_end, frame_start,
    output frame_cnt
  );

  modport slave (
    output ce,
    input  hsync, vsync, display_on,
    input  hpos, vpos,
    input  line_end, frame_start,
    input  frame_cnt
  );

endinterface

// File: rtl/vga_timing_core_axis.sv
// One raster axis: position counter plus ACTIVE/FRONT/
// SYNC/BACK phase FSM with registered sync/active.
import vga_timing_pkg::*;

module vga_axis_timer #(
  parameter int ACTIVE   = H_ACTIVE_D,
  parameter int FRONT    = H_FRONT_D,
  parameter int SYNC     = H_SYNC_D,
  parameter int BACK     = H_BACK_D,
  parameter bit SYNC_POL = SYNC_POL_D
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       advance,
  output logic [9:0] pos,
  output logic       sync,
  output logic       active,
  output logic       wrap
);

  localparam int TOTAL = ACTIVE + FRONT + SYNC + BACK;

  localparam logic [9:0] E_ACT = 10'(ACTIVE - 1);
  localparam logic [9:0] E_FRT = 10'(ACTIVE + FRONT - 1);
  localparam logic [9:0] E_SYN = 10'(ACTIVE + FRONT + SYNC - 1);
  localparam logic [9:0] E_TOT = 10'(TOTAL - 1);

  phase_t     phase;
  phase_t     phase_nxt;
  logic [9:0] pos_nxt;

  // Out-of-range positions behave as the last BACK count.
  assign wrap = (pos >= E_TOT);

  always_comb begin
    pos_nxt   = pos;
    phase_nxt = phase;
    if (advance) begin
      if (wrap) begin
        pos_nxt   = '0;
        phase_nxt = ST_ACTIVE;
      end else begin
        pos_nxt = pos + 10'd1;
        unique case (phase)
          ST_ACTIVE:
            if (pos == E_ACT) phase_nxt = ST_FRONT;
          ST_FRONT:
            if (pos == E_FRT) phase_nxt = ST_SYNC;
          ST_SYNC:
            if (pos == E_SYN) phase_nxt = ST_BACK;
          ST_BACK:
            phase_nxt = ST_BACK;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos    <= E_TOT;
      phase  <= ST_BACK;
      sync   <= ~SYNC_POL;
      active <= 1'b0;
    end else if (advance) begin
      pos    <= pos_nxt;
      phase  <= phase_nxt;
      sync   <= (phase_nxt == ST_SYNC) ? SYNC_POL
                                       : ~SYNC_POL;
      active <= (phase_nxt == ST_ACTIVE);
    end
  end

endmodule

// File: rtl/vga_timing_core.sv
// VGA raster timing source: chained H/V axis timers, strobes,
// and a frame counter built only with VGA_TIMING_FRAME_CNT_EN.
import vga_timing_pkg::*;

module vga_timing_core #(
  parameter int H_ACTIVE = H_ACTIVE_D,
  parameter int H_FRONT  = H_FRONT_D,
  parameter int H_SYNC   = H_SYNC_D,
  parameter int H_BACK   = H_BACK_D,
  parameter int V_ACTIVE = V_ACTIVE_D,
  parameter int V_FRONT  = V_FRONT_D,
  parameter int V_SYNC   = V_SYNC_D,
  parameter int V_BACK   = V_BACK_D,
  parameter bit SYNC_POL = SYNC_POL_D
) (
  input logic        clk,
  input logic        rst_n,
  vga_timing_if.master vga
);

  logic h_wrap;
  logic v_wrap;
  logic h_active;
  logic v_active;
  logic v_adv;
  logic frame_entry;

  vga_axis_timer #(
    .ACTIVE   (H_ACTIVE),
    .FRONT    (H_FRONT),
    .SYNC     (H_SYNC),
    .BACK     (H_BACK),
    .SYNC_POL (SYNC_POL)
  ) u_h (
    .clk     (clk),
    .rst_n   (rst_n),
    .advance (vga.ce),
    .pos     (vga.hpos),
    .sync    (vga.hsync),
    .active  (h_active),
    .wrap    (h_wrap)
  );

  assign v_adv = vga.ce & h_wrap;

  vga_axis_timer #(
    .ACTIVE   (V_ACTIVE),
    .FRONT    (V_FRONT),
    .SYNC     (V_SYNC),
    .BACK     (V_BACK),
    .SYNC_POL (SYNC_POL)
  ) u_v (
    .clk     (clk),
    .rst_n   (rst_n),
    .advance (v_adv),
    .pos     (vga.vpos),
    .sync    (vga.vsync),
    .active  (v_active),
    .wrap    (v_wrap)
  );

  assign frame_entry    = v_adv & v_wrap;
  assign vga.display_on = h_active & v_active;
  assign vga.line_end   = h_wrap;

  // Registered from the wrap decode so it lands with (0,0).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vga.frame_start <= 1'b0;
    end else if (vga.ce) begin
      vga.frame_start <= frame_entry;
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [7:0] fcnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fcnt <= 8'd0;
    end else if (frame_entry) begin
      fcnt <= fcnt + 8'd1;
    end
  end

  assign vga.frame_cnt = fcnt;
`else
  assign vga.frame_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_vga_timing_core.sv
// Directed bench: full 640x480 instance for line/reset timing,
// a shrunken instance (16x9) for whole-frame and counter runs.
`timescale 1ns/1ps

module tb_vga_timing_core;

  logic clk;
  logic rst_n;
  logic ce;

  int n;
  int bad;
  int errs;
  int checks;

  vga_timing_if va();
  vga_timing_if vb();

  assign va.ce = ce;
  assign vb.ce = ce;

  vga_timing_core dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .vga   (va)
  );

  vga_timing_core #(
    .H_ACTIVE (8), .H_FRONT (2), .H_SYNC (3), .H_BACK (3),
    .V_ACTIVE (4), .V_FRONT (1), .V_SYNC (2), .V_BACK (2)
  ) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .vga   (vb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got,
                     input int exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Expected outputs after n pixel advances since reset.
  function automatic logic [32:0] expv(
    int cnt, int ha, int hf, int hs, int hb,
    int vac, int vfp, int vsw, int vbp);
    int ht, vt, h, v, fc;
    logic hsn, vsn, de, le, fs;
    ht = ha + hf + hs + hb;
    vt = vac + vfp + vsw + vbp;
    if (cnt == 0) begin
      h = ht - 1; v = vt - 1; fc = 0;
    end else begin
      h  = (cnt - 1) % ht;
      v  = ((cnt - 1) / ht) % vt;
      fc = ((cnt - 1) / (ht * vt) + 1) % 256;
    end
`ifndef VGA_TIMING_FRAME_CNT_EN
    fc = 0;
`endif
    hsn = !(h >= ha + hf && h < ha + hf + hs);
    vsn = !(v >= vac + vfp && v < vac + vfp + vsw);
    de  = (h < ha) && (v < vac);
    le  = (h == ht - 1);
    fs  = (cnt != 0) && (h == 0) && (v == 0);
    return {hsn, vsn, de, le, fs, 10'(h), 10'(v), 8'(fc)};
  endfunction

  task automatic scan();
    if ({va.hsync, va.vsync, va.display_on, va.line_end,
         va.frame_start, va.hpos, va.vpos, va.frame_cnt}
        !== expv(n, 640, 16, 96, 48, 480, 10, 2, 33))
      bad++;
    if ({vb.hsync, vb.vsync, vb.display_on, vb.line_end,
         vb.frame_start, vb.hpos, vb.vpos, vb.frame_cnt}
        !== expv(n, 8, 2, 3, 3, 4, 1, 2, 2))
      bad++;
  endtask

  task automatic tick();
    @(posedge clk);
    if (ce && rst_n) n++;
    #1;
    scan();
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs, le, vs, hsb, de, fs, cyc, last, seen;
    int fc255, fc_first;
    logic fs_prev;
    rst_n = 1'b0; ce = 1'b0;
    n = 0; bad = 0; errs = 0; checks = 0;
`ifdef VGA_TIMING_FRAME_CNT_EN
    fc255 = 255; fc_first = 1;
`else
    fc255 = 0; fc_first = 0;
`endif

    repeat (3) tick();
    chk("rst_hpos", va.hpos, 799);
    chk("rst_vpos", va.vpos, 524);
    chk("rst_hsync", va.hsync, 1);
    chk("rst_vsync", va.vsync, 1);
    chk("rst_de", va.display_on, 0);
    chk("rst_line_end", va.line_end, 1);
    chk("rst_frame_start", va.frame_start, 0);
    chk("rst_frame_cnt", va.frame_cnt, 0);
    chk("rst_b_hpos", vb.hpos, 15);
    chk("rst_b_vpos", vb.vpos, 8);

    rst_n = 1'b1; ce = 1'b1;
    tick();
    chk("first_hpos", va.hpos, 0);
    chk("first_vpos", va.vpos, 0);
    chk("first_de", va.display_on, 1);
    chk("first_fs", va.frame_start, 1);
    chk("first_le", va.line_end, 0);
    chk("first_b_fs", vb.frame_start, 1);
    chk("first_fc", vb.frame_cnt, fc_first);
    chk("reset_scan_bad", bad, 0);

    bad = 0; hs = 0; le = 0;
    for (int i = 0; i < 800; i++) begin
      if (!va.hsync) hs++;
      if (va.line_end) le++;
      tick();
    end
    chk("line_hsync_cycles", hs, 96);
    chk("line_end_cycles", le, 1);
    chk("wrap_hpos", va.hpos, 0);
    chk("wrap_vpos", va.vpos, 1);
    chk("line_scan_bad", bad, 0);

    while (((n - 1) % 144) != 0) tick();
    bad = 0; vs = 0; hsb = 0; de = 0; fs = 0;
    repeat (288) begin
      if (!vb.vsync) vs++;
      if (!vb.hsync) hsb++;
      if (vb.display_on) de++;
      if (vb.frame_start) fs++;
      tick();
    end
    chk("frame_vsync_cycles", vs, 64);
    chk("frame_hsync_cycles", hsb, 54);
    chk("frame_de_cycles", de, 64);
    chk("frame_start_cycles", fs, 2);
    chk("frame_scan_bad", bad, 0);

    bad = 0; cyc = 0; last = -1; seen = 0;
    fs_prev = vb.frame_start;
    for (int k = 0; k < 1200; k++) begin
      ce = (k % 4 == 0);
      tick();
      cyc++;
      if (vb.frame_start && !fs_prev) begin
        if (last >= 0) begin
          chk("ce_frame_len", cyc - last, 576);
          seen++;
        end
        last = cyc;
      end
      fs_prev = vb.frame_start;
    end
    chk("ce_intervals", int'(seen >= 1), 1);
    chk("ce_scan_bad", bad, 0);
    ce = 1'b1;

    for (int k = 0; k < 800 && ((n - 1) % 800) != 300; k++)
      tick();
    chk("pre_rst_hpos", va.hpos, 300);
    rst_n = 1'b0; n = 0;
    #1;
    chk("mid_rst_hpos", va.hpos, 799);
    chk("mid_rst_vpos", va.vpos, 524);
    chk("mid_rst_le", va.line_end, 1);
    chk("mid_rst_de", va.display_on, 0);
    chk("mid_rst_hsync", va.hsync, 1);
    chk("mid_rst_b_hpos", vb.hpos, 15);
    tick();
    rst_n = 1'b1;
    tick();
    chk("restart_hpos", va.hpos, 0);
    chk("restart_vpos", va.vpos, 0);
    chk("restart_fs", va.frame_start, 1);

    bad = 0;
    while (n < 254 * 144 + 1) tick();
    chk("fc_frame255", vb.frame_cnt, fc255);
    repeat (144) tick();
    chk("fc_wrap", vb.frame_cnt, 0);
    chk("fc_scan_bad", bad, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
